// File: rtl/speed_ramp_control.sv
// speed_ramp_control: three debounced buttons drive a target speed level
// through one of four cycle modes; the reported speed level slews toward
// the target one level per RAMP_CYCLES clocks.

// Two-flop synchroniser plus debounce counter for one asynchronous button.
// press_c is high in the cycle before the edge on which the debounced
// state rises, so the consumer can register its reaction on that same edge.
module speed_ramp_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_c
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          sync_meta;
    logic          sync_q;
    logic          state;
    logic [CW-1:0] count;
    logic          differ_c;
    logic          flip_c;

    // The counter holds how many consecutive samples have disagreed with the
    // accepted state; one more disagreeing sample beyond CYCLES flips it.
    assign differ_c = (sync_q != state);
    assign flip_c   = differ_c && (count == CW'(CYCLES));
    assign press_c  = flip_c && sync_q;

    // Synchroniser, debounced state and disagreement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            state     <= 1'b0;
            count     <= '0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
            if (!differ_c) begin
                count <= '0;
            end else if (flip_c) begin
                state <= sync_q;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

module speed_ramp_control #(
    parameter int unsigned LEVELS          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RAMP_CYCLES     = 8,
    parameter int unsigned SKIP_FIRST      = 1,
    localparam int unsigned W = ($clog2(LEVELS) > 1) ? $clog2(LEVELS) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_cycle,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic [1:0]   mode,
    output logic [W-1:0] target_level,
    output logic [W-1:0] speed_value,
    output logic         direction_up,
    output logic         ramping,
    output logic         press_evt
);

    localparam int unsigned TW        = ($clog2(RAMP_CYCLES) > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [W-1:0]  MAX_LVL  = W'(LEVELS - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(RAMP_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_PINGPONG = 2'd0,
        MODE_WRAP     = 2'd1,
        MODE_SATURATE = 2'd2,
        MODE_LOCK     = 2'd3
    } mode_e;

    logic          cycle_press_c;
    logic          up_press_c;
    logic          down_press_c;

    logic          up_evt_c;
    logic          down_evt_c;
    logic          cycle_evt_c;
    logic          any_evt_c;
    logic          locked_c;
    logic          at_max_c;
    logic          at_min_c;

    logic          skip_armed;
    logic          skip_next;
    logic [W-1:0]  target_next;
    logic          dir_next;
    logic          evt_next;

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [W-1:0]  speed_next;

    speed_ramp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_cycle (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_cycle),
        .press_c (cycle_press_c)
    );

    speed_ramp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_up),
        .press_c (up_press_c)
    );

    speed_ramp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_down),
        .press_c (down_press_c)
    );

    // Resolve same-cycle conflicts: up+down cancel, and either one beats cycle.
    always_comb begin
        up_evt_c    = up_press_c && !down_press_c;
        down_evt_c  = down_press_c && !up_press_c;
        cycle_evt_c = cycle_press_c && !up_press_c && !down_press_c;
        any_evt_c   = up_evt_c || down_evt_c || cycle_evt_c;
        locked_c    = (mode_e'(mode) == MODE_LOCK);
        at_max_c    = (target_level == MAX_LVL);
        at_min_c    = (target_level == '0);
    end

    // Next target, direction, skip flag and press pulse from the surviving event.
    always_comb begin
        target_next = target_level;
        dir_next    = direction_up;
        evt_next    = 1'b0;
        skip_next   = skip_armed;

        if (any_evt_c && !locked_c) begin
            if ((SKIP_FIRST != 0) && skip_armed) begin
                skip_next = 1'b0;
            end else begin
                evt_next = 1'b1;
                if (up_evt_c) begin
                    if (!at_max_c) begin
                        target_next = target_level + W'(1);
                    end
                end else if (down_evt_c) begin
                    if (!at_min_c) begin
                        target_next = target_level - W'(1);
                    end
                end else begin
                    case (mode_e'(mode))
                        MODE_PINGPONG: begin
                            if (direction_up) begin
                                if (!at_max_c) begin
                                    target_next = target_level + W'(1);
                                end else begin
                                    target_next = target_level - W'(1);
                                    dir_next    = 1'b0;
                                end
                            end else begin
                                if (!at_min_c) begin
                                    target_next = target_level - W'(1);
                                end else begin
                                    target_next = target_level + W'(1);
                                    dir_next    = 1'b1;
                                end
                            end
                        end
                        MODE_WRAP: begin
                            target_next = at_max_c ? '0 : (target_level + W'(1));
                        end
                        MODE_SATURATE: begin
                            if (!at_max_c) begin
                                target_next = target_level + W'(1);
                            end
                        end
                        default: begin
                            target_next = target_level;
                        end
                    endcase
                end
            end
        end
    end

    // Ramp: one step toward the current target every RAMP_CYCLES clocks;
    // a target change mid-ramp keeps the elapsed time.
    always_comb begin
        speed_next = speed_value;
        timer_next = '0;
        if (speed_value != target_level) begin
            if (timer == TIMER_END) begin
                timer_next = '0;
                speed_next = (target_level > speed_value) ? (speed_value + W'(1))
                                                          : (speed_value - W'(1));
            end else begin
                timer_next = timer + TW'(1);
            end
        end
    end

    // Registered control state and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_level <= '0;
            speed_value  <= '0;
            direction_up <= 1'b1;
            press_evt    <= 1'b0;
            skip_armed   <= 1'b1;
            timer        <= '0;
        end else begin
            target_level <= target_next;
            speed_value  <= speed_next;
            direction_up <= dir_next;
            press_evt    <= evt_next;
            skip_armed   <= skip_next;
            timer        <= timer_next;
        end
    end

    assign ramping = (speed_value != target_level);

endmodule

// File: tb/tb_speed_ramp_control.sv
// Bench for speed_ramp_control: two instances (LEVELS=6 and LEVELS=5) share
// all inputs; a behavioural model predicts every output on every cycle.
module tb_speed_ramp_control;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_cycle;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] mode;

    logic [2:0] target_a, speed_a, target_b, speed_b;
    logic       dir_a, ramping_a, evt_a, dir_b, ramping_b, evt_b;

    int n_pass   = 0;
    int n_checks = 0;

    // model state, index 0 = LEVELS 6, index 1 = LEVELS 5
    int lvls[2]     = '{6, 5};
    int m_target[2] = '{0, 0};
    int m_dir[2]    = '{1, 1};
    int m_armed[2]  = '{1, 1};
    int m_evt[2]    = '{0, 0};
    int m_speed[2]  = '{0, 0};
    int m_elapsed[2] = '{0, 0};

    always #5 clk = ~clk;

    speed_ramp_control #(.LEVELS(6), .DEBOUNCE_CYCLES(D), .RAMP_CYCLES(R), .SKIP_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .btn_cycle(btn_cycle), .btn_up(btn_up), .btn_down(btn_down),
        .mode(mode), .target_level(target_a), .speed_value(speed_a), .direction_up(dir_a),
        .ramping(ramping_a), .press_evt(evt_a)
    );

    speed_ramp_control #(.LEVELS(5), .DEBOUNCE_CYCLES(D), .RAMP_CYCLES(R), .SKIP_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .btn_cycle(btn_cycle), .btn_up(btn_up), .btn_down(btn_down),
        .mode(mode), .target_level(target_b), .speed_value(speed_b), .direction_up(dir_b),
        .ramping(ramping_b), .press_evt(evt_b)
    );

    // Speed model: while behind the target, count clocks spent ramping and
    // move one level after every R of them.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_speed[i]   <= 0;
                m_elapsed[i] <= 0;
            end else if (m_speed[i] != m_target[i]) begin
                if (m_elapsed[i] + 1 == R) begin
                    m_elapsed[i] <= 0;
                    m_speed[i]   <= (m_target[i] > m_speed[i]) ? m_speed[i] + 1 : m_speed[i] - 1;
                end else begin
                    m_elapsed[i] <= m_elapsed[i] + 1;
                end
            end else begin
                m_elapsed[i] <= 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d]: observed %0d expected %0d", tag, inst, obs, exp);
    endtask

    task automatic check_all();
        chk("target", 0, 32'(target_a), 32'(m_target[0]));
        chk("speed", 0, 32'(speed_a), 32'(m_speed[0]));
        chk("dir", 0, 32'(dir_a), 32'(m_dir[0]));
        chk("ramping", 0, 32'(ramping_a), 32'(m_speed[0] != m_target[0]));
        chk("press_evt", 0, 32'(evt_a), 32'(m_evt[0]));
        chk("target", 1, 32'(target_b), 32'(m_target[1]));
        chk("speed", 1, 32'(speed_b), 32'(m_speed[1]));
        chk("dir", 1, 32'(dir_b), 32'(m_dir[1]));
        chk("ramping", 1, 32'(ramping_b), 32'(m_speed[1] != m_target[1]));
        chk("press_evt", 1, 32'(evt_b), 32'(m_evt[1]));
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    // Apply one accepted button mask to one model instance.
    task automatic apply_one(input int i, input logic [2:0] mask);
        int kind;
        int lmax;
        int step;
        lmax = lvls[i] - 1;
        if (mask[1] && mask[2]) kind = 0;
        else if (mask[1])       kind = 1;
        else if (mask[2])       kind = 2;
        else if (mask[0])       kind = 3;
        else                    kind = 0;
        if (kind == 0 || mode == 2'd3) return;
        if (m_armed[i] != 0) begin
            m_armed[i] = 0;
            return;
        end
        m_evt[i] = 1;
        case (kind)
            1: m_target[i] = (m_target[i] < lmax) ? m_target[i] + 1 : lmax;
            2: m_target[i] = (m_target[i] > 0) ? m_target[i] - 1 : 0;
            default: begin
                if (mode == 2'd0) begin
                    step = (m_dir[i] != 0) ? 1 : -1;
                    if (m_target[i] + step > lmax || m_target[i] + step < 0) begin
                        m_dir[i] = (m_dir[i] != 0) ? 0 : 1;
                        step = -step;
                    end
                    m_target[i] = m_target[i] + step;
                end else if (mode == 2'd1) begin
                    m_target[i] = (m_target[i] + 1) % lvls[i];
                end else begin
                    m_target[i] = (m_target[i] < lmax) ? m_target[i] + 1 : lmax;
                end
            end
        endcase
    endtask

    task automatic set_buttons(input logic [2:0] mask);
        btn_cycle = mask[0];
        btn_up    = mask[1];
        btn_down  = mask[2];
    endtask

    // Clean press: hold, expect the event exactly D+2 edges after the first
    // sampling edge, then release long enough for the debounce to settle.
    // With early set, return right after the event with the buttons held.
    task automatic press(input logic [2:0] mask, input int extra, input bit early);
        int last;
        last = early ? D + 2 : D + 2 + extra;
        set_buttons(mask);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == D + 2) begin
                apply_one(0, mask);
                apply_one(1, mask);
            end
            check_all();
            m_evt[0] = 0;
            m_evt[1] = 0;
        end
        if (!early) begin
            set_buttons(3'b000);
            repeat (D + 4) tick();
        end
    endtask

    task automatic glitch(input logic [2:0] mask, input int len);
        set_buttons(mask);
        repeat (len) tick();
        set_buttons(3'b000);
        repeat (D + 6) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_target[i] = 0;
            m_dir[i]    = 1;
            m_armed[i]  = 1;
            m_evt[i]    = 0;
        end
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    localparam logic [2:0] CYC  = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] DOWN = 3'b100;

    int pp_exp[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
    logic [2:0] rmask;
    int r;

    initial begin
        reset = 1'b1;
        mode  = 2'd0;
        set_buttons(3'b000);
        do_reset(3);

        // ping-pong sweep with one swallowed dummy press
        mode = 2'd0;
        press(CYC, 0, 0);
        chk("skip_dummy", 0, 32'(target_a), 32'd0);
        for (int n = 0; n < 12; n++) begin
            press(CYC, n % 3, 0);
            chk("pp_table", 0, 32'(target_a), 32'(pp_exp[n]));
            chk("pp_dir", 0, 32'(dir_a), (n >= 5 && n <= 9) ? 32'd0 : 32'd1);
        end
        repeat (3 * R) tick();

        // wrap at the top level
        mode = 2'd1;
        repeat (3) press(UP, 1, 0);
        chk("wrap_pre", 0, 32'(target_a), 32'd5);
        press(CYC, 0, 0);
        chk("wrap", 0, 32'(target_a), 32'd0);
        chk("wrap", 1, 32'(target_b), 32'd0);
        repeat (6 * R) tick();

        // saturate: press accepted with no level change
        mode = 2'd2;
        repeat (6) press(UP, 0, 0);
        press(CYC, 0, 0);
        chk("saturate", 0, 32'(target_a), 32'd5);
        repeat (6 * R) tick();
        chk("settled_speed", 0, 32'(speed_a), 32'd5);

        // short glitches never produce an event
        glitch(UP, D - 1);
        glitch(DOWN, 1);
        chk("glitch", 0, 32'(target_a), 32'd5);

        // simultaneous presses
        press(UP | DOWN, 0, 0);
        chk("up_down", 0, 32'(target_a), 32'd5);
        press(DOWN | CYC, 0, 0);
        chk("down_cyc", 0, 32'(target_a), 32'd4);
        repeat (2 * R) tick();

        // lock mode ignores buttons and leaves the skip flag armed
        do_reset(1);
        mode = 2'd3;
        press(CYC, 0, 0);
        press(UP, 0, 0);
        press(DOWN, 0, 0);
        chk("lock", 0, 32'(target_a), 32'd0);
        mode = 2'd0;
        press(UP, 0, 0);
        chk("lock_skip", 0, 32'(target_a), 32'd0);
        press(UP, 0, 0);
        chk("after_lock", 0, 32'(target_a), 32'd1);

        // reset mid-ramp with the button held through reset
        press(UP, 0, 1);
        chk("mid_ramp", 0, 32'(ramping_a), 32'd1);
        do_reset(1);
        chk("reset_dir", 0, 32'(dir_a), 32'd1);
        press(UP, 0, 0);
        chk("held_skip", 0, 32'(target_a), 32'd0);
        press(UP, 0, 0);
        chk("post_reset", 0, 32'(target_a), 32'd1);

        // randomized traffic
        for (int it = 0; it < 70; it++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_reset($urandom_range(1, 2));
            end else if (r < 15) begin
                mode = 2'($urandom_range(0, 3));
            end else if (r < 22) begin
                rmask = 3'($urandom_range(1, 7));
                glitch(rmask, $urandom_range(1, D - 1));
            end else begin
                if ($urandom_range(0, 9) < 7) rmask = 3'b001 << $urandom_range(0, 2);
                else rmask = 3'($urandom_range(1, 7));
                press(rmask, $urandom_range(0, 6), 0);
            end
            repeat ($urandom_range(0, 10)) tick();
        end

        // saturation on the five-level instance
        do_reset(1);
        mode = 2'd2;
        press(UP, 0, 0);
        repeat (10) press(UP, 0, 0);
        chk("sat5", 1, 32'(target_b), 32'd4);
        chk("sat6", 0, 32'(target_a), 32'd5);
        repeat (6 * R) tick();
        chk("sat5_speed", 1, 32'(speed_b), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
